// File: rtl/array_sp_ctrl.sv
// Request-side controller for a 512x16 single-port SRAM: zero-fills the array after reset,
// then turns a valid/ready request stream into RW0 cycles and returns read data in order.
`timescale 1ns/1ps
module array_sp_ctrl #(
  parameter int RESP_DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [8:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        init_done,
  output logic [8:0]  mem_RW0_addr,
  output logic        mem_RW0_en,
  output logic        mem_RW0_wmode,
  output logic [15:0] mem_RW0_wdata,
  input  logic [15:0] mem_RW0_rdata,
  output logic        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; ready never
  // depends on the same stream's valid, and req_ready never depends on resp_ready.

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state;
  logic [8:0]    init_cnt;
  logic          inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [15:0]   fifo_q [RESP_DEPTH];

  logic [CW:0] credit_used;
  logic        issue;
  logic        rd_issue;
  logic        push;
  logic        pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A read may only issue if its return is guaranteed a free FIFO slot.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req_ready   = (state == S_RUN) && (req_write || (credit_used < DEPTH_W));
  assign issue       = req_valid && req_ready;
  assign rd_issue    = issue && !req_write;
  assign push        = inflight;
  assign pop         = resp_valid && resp_ready;
  assign resp_valid  = (count != '0);
  assign resp_rdata  = fifo_q[rd_ptr];
  assign fsm_state   = (state == S_RUN);

  always_comb begin
    mem_RW0_en    = 1'b0;
    mem_RW0_wmode = 1'b0;
    mem_RW0_addr  = '0;
    mem_RW0_wdata = '0;
    if (reset_n) begin
      if (state == S_INIT) begin
        mem_RW0_en    = 1'b1;
        mem_RW0_wmode = 1'b1;
        mem_RW0_addr  = init_cnt;
      end else if (issue) begin
        mem_RW0_en    = 1'b1;
        mem_RW0_wmode = req_write;
        mem_RW0_addr  = req_addr;
        mem_RW0_wdata = req_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      inflight  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          inflight <= 1'b0;
          if (init_cnt == 9'd511) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 9'd1;
          end
        end
        default: begin
          inflight <= rd_issue;
        end
      endcase
    end
  end

  // Read data from the macro is valid the cycle after the read was issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= mem_RW0_rdata;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always @(posedge clock) begin
    if (reset_n && push) assert (count < CW'(RESP_DEPTH));
  end

endmodule

// File: tb/tb_array_sp_ctrl.sv
// Directed bench for array_sp_ctrl with a behavioural 512x16 SRAM and an in-order
// response scoreboard fed by the request driver and drained by a monitor.
`timescale 1ns/1ps
module tb_array_sp_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_rdata;
  logic        init_done;
  logic [8:0]  mem_RW0_addr;
  logic        mem_RW0_en;
  logic        mem_RW0_wmode;
  logic [15:0] mem_RW0_wdata;
  logic [15:0] mem_RW0_rdata = '0;
  logic        fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  int stall_total = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sram [512];

  // clock / reset block
  always #5 clock = ~clock;

  array_sp_ctrl #(.RESP_DEPTH(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .mem_RW0_addr(mem_RW0_addr), .mem_RW0_en(mem_RW0_en),
    .mem_RW0_wmode(mem_RW0_wmode), .mem_RW0_wdata(mem_RW0_wdata),
    .mem_RW0_rdata(mem_RW0_rdata), .fsm_state(fsm_state)
  );

  // SRAM macro model: one-cycle read latency, read data held until the next read.
  initial for (int i = 0; i < 512; i++) sram[i] = 16'hDEAD;
  always @(posedge clock) begin
    if (mem_RW0_en) begin
      if (mem_RW0_wmode) sram[mem_RW0_addr] <= mem_RW0_wdata;
      else               mem_RW0_rdata <= sram[mem_RW0_addr];
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset_n && resp_valid && resp_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got 0x%0h, expected no response", resp_rdata);
      end else begin
        check("resp_rdata", {16'h0, resp_rdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // driver: called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic wr, input logic [8:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp);
    bit accepted = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    for (int t = 0; t < 64; t++) begin
      @(negedge clock);
      if (req_ready) begin
        accepted = 1;
        break;
      end
      stall_total++;
    end
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: got no req_ready, expected acceptance of addr 0x%0h", addr);
    end else if (!wr) begin
      exp_q.push_back(exp);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic rd(input logic [8:0] addr, input logic [15:0] exp);
    issue(1'b0, addr, 16'h0, exp);
  endtask

  task automatic wr(input logic [8:0] addr, input logic [15:0] data);
    issue(1'b1, addr, data, 16'h0);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_and_init();
    int strobes = 0;
    int addr_err = 0;
    reset_n = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_en", mem_RW0_en, 0);
    check("rst_mem_other", {mem_RW0_wmode, mem_RW0_addr, mem_RW0_wdata}, 0);
    check("rst_fsm_state", fsm_state, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k <= 512; k++) begin
      @(negedge clock);
      if (k < 512) begin
        if (mem_RW0_en && mem_RW0_wmode && mem_RW0_wdata == 16'h0) strobes++;
        if (mem_RW0_addr != k[8:0]) addr_err++;
      end
      if (k == 511) begin
        check("init_done_c511", init_done, 0);
        check("req_ready_c511", req_ready, 0);
      end
      if (k == 512) begin
        check("init_done_c512", init_done, 1);
        check("req_ready_c512", req_ready, 1);
        check("mem_en_idle_c512", mem_RW0_en, 0);
      end
    end
    check("init_strobes", strobes, 512);
    check("init_addr_seq_err", addr_err, 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int p0;
    resp_ready = 1'b1;
    reset_and_init();

    // every address reads back zero after the fill
    for (int a = 0; a < 512; a++) rd(a[8:0], 16'h0000);
    wait_drain();

    // write then read next cycle, check the two-cycle read latency
    wr(9'h1FF, 16'hA5C3);
    rd(9'h1FF, 16'hA5C3);
    @(negedge clock);
    check("rd_lat_n1_valid", resp_valid, 0);
    @(negedge clock);
    check("rd_lat_n2_valid", resp_valid, 1);
    check("rd_lat_n2_data", resp_rdata, 16'hA5C3);
    wait_drain();

    // streaming reads with full throughput
    for (int i = 0; i < 16; i++) wr(i[8:0], i[15:0]);
    stall_total = 0;
    p0 = pop_cnt;
    for (int i = 0; i < 16; i++) rd(i[8:0], i[15:0]);
    check("stream_stalls", stall_total, 0);
    repeat (2) @(negedge clock);
    #1;
    check("stream_consecutive_pops", pop_cnt - p0, 16);
    wait_drain();

    // back-pressure: three reads fill the credits, a write still passes
    resp_ready = 1'b0;
    stall_total = 0;
    p0 = pop_cnt;
    rd(9'd0, 16'd0);
    rd(9'd1, 16'd1);
    rd(9'd2, 16'd2);
    check("bp_first3_stalls", stall_total, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 9'd3;
    @(negedge clock);
    check("bp_read_blocked_a", req_ready, 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("bp_read_blocked_b", req_ready, 0);
    @(posedge clock);
    #1;
    stall_total = 0;
    wr(9'd20, 16'h1234);
    check("bp_write_stalls", stall_total, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 9'd3;
    @(negedge clock);
    check("bp_read_blocked_c", req_ready, 0);
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    rd(9'd3, 16'd3);
    rd(9'd4, 16'd4);
    wait_drain();
    check("bp_all_returned", pop_cnt - p0, 5);
    rd(9'd20, 16'h1234);
    wait_drain();

    // push and pop in the same cycle keep one entry buffered
    resp_ready = 1'b0;
    rd(9'd7, 16'd7);
    @(posedge clock);
    #1;
    rd(9'd8, 16'd8);
    resp_ready = 1'b1;
    @(negedge clock);
    check("pp_head_valid", resp_valid, 1);
    @(negedge clock);
    check("pp_count_held", resp_valid, 1);
    check("pp_data_b", resp_rdata, 16'd8);
    @(negedge clock);
    check("pp_empty", resp_valid, 0);
    wait_drain();

    // reset mid-stream with two buffered and one in flight
    resp_ready = 1'b0;
    rd(9'd1, 16'd1);
    rd(9'd2, 16'd2);
    rd(9'd3, 16'd3);
    check("mid_pre_valid", resp_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_mem_en", mem_RW0_en, 0);
    check("mid_rst_init_done", init_done, 0);
    exp_q.delete();
    resp_ready = 1'b1;
    reset_and_init();
    rd(9'h1FF, 16'h0000);
    rd(9'd20, 16'h0000);
    rd(9'd3, 16'h0000);
    wait_drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
    $fatal(1);
  end

endmodule
